// File: rtl/i2s_rx.sv
// I2S receiver: oversamples BCLK/LRCK/SDATA on clk and deserialises MSB-first words into held left/right outputs.
// Word and its valid pulse land one clk after the rise that carries the LSB; there is no backpressure, outputs are simply overwritten.
module i2s_rx #(
    parameter int WIDTH = 24,
    parameter int SLOT  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bclk_in,
    input  logic             lrck_in,
    input  logic             sdata_in,
    output logic [WIDTH-1:0] left_out,
    output logic [WIDTH-1:0] right_out,
    output logic             left_valid,
    output logic             right_valid,
    output logic             frame_err
);
    localparam int BW = $clog2(WIDTH + 1);
    localparam int SW = $clog2(SLOT + 2);
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);
    localparam logic [SW-1:0] SLOT_MAX = SW'(SLOT);

    typedef enum logic [1:0] {
        SYNC  = 2'd0,
        SKIP  = 2'd1,
        SHIFT = 2'd2,
        WAIT  = 2'd3
    } state_t;

    logic [1:0]       bclk_sync_q, lrck_sync_q, sdata_sync_q;
    logic             bclk_prev_q;
    logic             lr_prev_q, armed_q;
    state_t           state_q, state_d;
    logic             chan_q, chan_d;
    logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [SW-1:0]    slot_cnt_q, slot_cnt_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [WIDTH-1:0] left_q, left_d, right_q, right_d;
    logic             lvld_q, lvld_d, rvld_q, rvld_d, ferr_q, ferr_d;

    logic             rise, lr, sd, lr_edge, slot_ovf;
    logic [SW-1:0]    slot_inc;
    logic [WIDTH-1:0] shift_word;

    assign rise       = bclk_sync_q[1] & ~bclk_prev_q;
    assign lr         = lrck_sync_q[1];
    assign sd         = sdata_sync_q[1];
    // The first rise after reset only learns the LRCK level, so reset never fakes an edge.
    assign lr_edge    = rise & armed_q & (lr != lr_prev_q);
    assign slot_inc   = slot_cnt_q + 1'b1;
    assign slot_ovf   = rise & ~lr_edge & (state_q != SYNC) & (slot_inc > SLOT_MAX);
    assign shift_word = {shreg_q[WIDTH-2:0], sd};

    always_comb begin
        state_d    = state_q;
        chan_d     = chan_q;
        bit_cnt_d  = bit_cnt_q;
        slot_cnt_d = slot_cnt_q;
        shreg_d    = shreg_q;
        left_d     = left_q;
        right_d    = right_q;
        lvld_d     = 1'b0;
        rvld_d     = 1'b0;
        ferr_d     = 1'b0;

        if (lr_edge) begin
            slot_cnt_d = SW'(1);
        end else if (rise && state_q != SYNC && slot_cnt_q <= SLOT_MAX) begin
            slot_cnt_d = slot_inc;
        end

        case (state_q)
            SYNC: begin
                if (lr_edge) begin
                    state_d = SKIP;
                    chan_d  = lr;
                end
            end
            // The edge rise was the delay bit; SKIP lasts one clk so the next rise is the MSB.
            SKIP: begin
                if (lr_edge) begin
                    chan_d = lr;
                end else begin
                    bit_cnt_d = '0;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                if (lr_edge) begin
                    ferr_d  = 1'b1;
                    state_d = SKIP;
                    chan_d  = lr;
                end else if (slot_ovf) begin
                    ferr_d  = 1'b1;
                    state_d = SYNC;
                end else if (rise) begin
                    shreg_d   = shift_word;
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d = WAIT;
                        if (chan_q) begin
                            right_d = shift_word;
                            rvld_d  = 1'b1;
                        end else begin
                            left_d = shift_word;
                            lvld_d = 1'b1;
                        end
                    end
                end
            end
            WAIT: begin
                if (lr_edge) begin
                    state_d = SKIP;
                    chan_d  = lr;
                end else if (slot_ovf) begin
                    ferr_d  = 1'b1;
                    state_d = SYNC;
                end
            end
            default: state_d = SYNC;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bclk_sync_q  <= '0;
            lrck_sync_q  <= '0;
            sdata_sync_q <= '0;
            bclk_prev_q  <= 1'b0;
            lr_prev_q    <= 1'b0;
            armed_q      <= 1'b0;
            state_q      <= SYNC;
            chan_q       <= 1'b0;
            bit_cnt_q    <= '0;
            slot_cnt_q   <= '0;
            shreg_q      <= '0;
            left_q       <= '0;
            right_q      <= '0;
            lvld_q       <= 1'b0;
            rvld_q       <= 1'b0;
            ferr_q       <= 1'b0;
        end else begin
            bclk_sync_q  <= {bclk_sync_q[0], bclk_in};
            lrck_sync_q  <= {lrck_sync_q[0], lrck_in};
            sdata_sync_q <= {sdata_sync_q[0], sdata_in};
            bclk_prev_q  <= bclk_sync_q[1];
            if (rise) begin
                lr_prev_q <= lr;
                armed_q   <= 1'b1;
            end
            state_q    <= state_d;
            chan_q     <= chan_d;
            bit_cnt_q  <= bit_cnt_d;
            slot_cnt_q <= slot_cnt_d;
            shreg_q    <= shreg_d;
            left_q     <= left_d;
            right_q    <= right_d;
            lvld_q     <= lvld_d;
            rvld_q     <= rvld_d;
            ferr_q     <= ferr_d;
        end
    end

    assign left_out    = left_q;
    assign right_out   = right_q;
    assign left_valid  = lvld_q;
    assign right_valid = rvld_q;
    assign frame_err   = ferr_q;
endmodule
